// File: rtl/packet_receiver_np.sv
// Packet receiver: parses SRC/DST/SIZE/DATA/CRC byte streams and writes trusted packets into per-port buffers.
// Optional build macro CRC_CHECK_EN enables XOR checksum verification of each packet before commit.
module packet_receiver_np #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int NUM_PORTS = 4,
  parameter int TS1       = 0,
  parameter int TS2       = 1,
  parameter int TS3       = 2,
  parameter int CNT_W     = 8
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic                           packet_valid_i,
  input  logic [UWIDTH-1:0]              pdata,
  input  logic [NUM_PORTS-1:0]           wfull_port,
  output logic                           stop_packet_send,
  output logic [NUM_PORTS-1:0]           wen_port,
  output logic [NUM_PORTS-1:0]           winc_port,
  output logic [NUM_PORTS*PTR_IN_SZ-1:0] waddr_in_port,
  output logic [NUM_PORTS*UWIDTH-1:0]    wdata_port,
  output logic [CNT_W-1:0]               drop_cnt,
  output logic                           crc_err
);

  localparam int PSEL_W = $clog2(NUM_PORTS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SRC    = 3'd1;
  localparam logic [2:0] DST    = 3'd2;
  localparam logic [2:0] SIZE   = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] CRC    = 3'd5;
  localparam logic [2:0] COMMIT = 3'd6;

  // Largest payload whose DST+SIZE+DATA+CRC still fits in 2^PTR_IN_SZ buffer bytes.
  localparam logic [PTR_IN_SZ-1:0] MAX_LEN = PTR_IN_SZ'((2 ** PTR_IN_SZ) - 3);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]                     state_q, state_d;
  logic                           trusted_q, trusted_d;
  logic                           drop_q, drop_d;
  logic [PSEL_W-1:0]              port_q, port_d;
  logic [PTR_IN_SZ-1:0]           cnt_q, cnt_d;
  logic [PTR_IN_SZ-1:0]           wptr_q, wptr_d;
  logic                           stop_q, stop_d;
  logic [NUM_PORTS-1:0]           wen_q, wen_d;
  logic [NUM_PORTS-1:0]           winc_q, winc_d;
  logic [NUM_PORTS*PTR_IN_SZ-1:0] waddr_q, waddr_d;
  logic [NUM_PORTS*UWIDTH-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]               drop_cnt_q, drop_cnt_d;
`ifdef CRC_CHECK_EN
  logic [UWIDTH-1:0]              crc_q, crc_d;
  logic                           crc_bad_q, crc_bad_d;
  logic                           crc_err_q, crc_err_d;
`endif

  logic              start;
  logic [2:0]        role;
  logic [PSEL_W-1:0] lane;
  logic              store;
  logic              drop_now;
  logic              keep;

  always_comb begin
    state_d    = state_q;
    trusted_d  = trusted_q;
    drop_d     = drop_q;
    port_d     = port_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    stop_d     = |wfull_port;
    wen_d      = '0;
    winc_d     = '0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    drop_cnt_d = drop_cnt_q;
    store      = 1'b0;
    drop_now   = drop_q;
    lane       = port_q;
`ifdef CRC_CHECK_EN
    crc_d      = crc_q;
    crc_bad_d  = crc_bad_q;
    crc_err_d  = 1'b0;
    keep       = trusted_q && !drop_q && !crc_bad_q;
`else
    keep       = trusted_q && !drop_q;
`endif

    start = packet_valid_i && !stop_q;
    // IDLE and COMMIT absorb the SRC byte directly, so packets can run back-to-back.
    role = state_q;
    if ((state_q == IDLE || state_q == COMMIT) && start) role = SRC;

    if (state_q == COMMIT) begin
      if (keep) winc_d[port_q] = 1'b1;
      else      drop_cnt_d = sat_inc(drop_cnt_q);
      waddr_d[int'(port_q)*PTR_IN_SZ +: PTR_IN_SZ] = '0;
`ifdef CRC_CHECK_EN
      crc_err_d = crc_bad_q;
`endif
      state_d = IDLE;
    end

    case (role)
      SRC: begin
        trusted_d = (pdata == UWIDTH'(TS1)) || (pdata == UWIDTH'(TS2)) ||
                    (pdata == UWIDTH'(TS3));
        drop_d    = 1'b0;
        wptr_d    = '0;
`ifdef CRC_CHECK_EN
        crc_d     = pdata;
        crc_bad_d = 1'b0;
`endif
        state_d   = DST;
      end
      DST, SIZE, DATA, CRC: begin
        if (!packet_valid_i) begin
          // Sender gave up mid-packet: discard it and free the lane offset.
          state_d    = IDLE;
          drop_cnt_d = sat_inc(drop_cnt_q);
          wptr_d     = '0;
          waddr_d[int'(port_q)*PTR_IN_SZ +: PTR_IN_SZ] = '0;
        end else begin
          store = 1'b1;
`ifdef CRC_CHECK_EN
          if (role != CRC) crc_d = crc_q ^ pdata;
`endif
          case (role)
            DST: begin
              lane    = pdata[UWIDTH-1 -: PSEL_W];
              port_d  = lane;
              if (wfull_port[lane]) drop_now = 1'b1;
              state_d = SIZE;
            end
            SIZE: begin
              cnt_d = pdata[PTR_IN_SZ-1:0];
              if (pdata[PTR_IN_SZ-1:0] > MAX_LEN) drop_now = 1'b1;
              state_d = (pdata[PTR_IN_SZ-1:0] == '0) ? CRC : DATA;
            end
            DATA: begin
              cnt_d = cnt_q - 1'b1;
              if (cnt_q == PTR_IN_SZ'(1)) state_d = CRC;
            end
            default: begin
`ifdef CRC_CHECK_EN
              crc_bad_d = (pdata != crc_q);
`endif
              state_d = COMMIT;
            end
          endcase
        end
      end
      default: ;
    endcase

    if (store) begin
      drop_d = drop_now;
      wptr_d = wptr_q + 1'b1;
      if (trusted_q && !drop_now) begin
        wen_d[lane] = 1'b1;
        wdata_d[int'(lane)*UWIDTH +: UWIDTH]       = pdata;
        waddr_d[int'(lane)*PTR_IN_SZ +: PTR_IN_SZ] = wptr_q;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      trusted_q  <= 1'b0;
      drop_q     <= 1'b0;
      port_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      stop_q     <= 1'b0;
      wen_q      <= '0;
      winc_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      drop_cnt_q <= '0;
`ifdef CRC_CHECK_EN
      crc_q      <= '0;
      crc_bad_q  <= 1'b0;
      crc_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      trusted_q  <= trusted_d;
      drop_q     <= drop_d;
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      stop_q     <= stop_d;
      wen_q      <= wen_d;
      winc_q     <= winc_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef CRC_CHECK_EN
      crc_q      <= crc_d;
      crc_bad_q  <= crc_bad_d;
      crc_err_q  <= crc_err_d;
`endif
    end
  end

  assign stop_packet_send = stop_q;
  assign wen_port         = wen_q;
  assign winc_port        = winc_q;
  assign waddr_in_port    = waddr_q;
  assign wdata_port       = wdata_q;
  assign drop_cnt         = drop_cnt_q;
`ifdef CRC_CHECK_EN
  assign crc_err          = crc_err_q;
`else
  assign crc_err          = 1'b0;
`endif

endmodule

// File: tb/tb_packet_receiver_np.sv
// Directed bench for packet_receiver_np with hand-computed expectations (default parameters).
module tb_packet_receiver_np;

  logic        clk1;
  logic        rst;
  logic        packet_valid_i;
  logic [7:0]  pdata;
  logic [3:0]  wfull_port;
  logic        stop_packet_send;
  logic [3:0]  wen_port;
  logic [3:0]  winc_port;
  logic [15:0] waddr_in_port;
  logic [31:0] wdata_port;
  logic [7:0]  drop_cnt;
  logic        crc_err;

  int n_checks = 0;
  int n_fails  = 0;

  packet_receiver_np dut (
    .clk1            (clk1),
    .rst             (rst),
    .packet_valid_i  (packet_valid_i),
    .pdata           (pdata),
    .wfull_port      (wfull_port),
    .stop_packet_send(stop_packet_send),
    .wen_port        (wen_port),
    .winc_port       (winc_port),
    .waddr_in_port   (waddr_in_port),
    .wdata_port      (wdata_port),
    .drop_cnt        (drop_cnt),
    .crc_err         (crc_err)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, let the DUT clock it, then settle away from the edge.
  task automatic byte_in(input logic v, input logic [7:0] d);
    packet_valid_i = v;
    pdata          = d;
    @(posedge clk1);
    #1;
  endtask

  initial begin
    logic [7:0] x;

    rst = 1'b1;
    packet_valid_i = 1'b0;
    pdata = 8'h00;
    wfull_port = 4'h0;
    #2;
    check("rst_wen",   {28'h0, wen_port}, 32'h0);
    check("rst_winc",  {28'h0, winc_port}, 32'h0);
    check("rst_waddr", {16'h0, waddr_in_port}, 32'h0);
    check("rst_wdata", wdata_port, 32'h0);
    check("rst_drop",  {24'h0, drop_cnt}, 32'h0);
    check("rst_stop",  {31'h0, stop_packet_send}, 32'h0);
    check("rst_crc",   {31'h0, crc_err}, 32'h0);
    @(posedge clk1);
    @(posedge clk1);
    #1 rst = 1'b0;

    // Trusted packet to port 0: SRC=01 DST=10 SIZE=2 AA BB CRC=02
    byte_in(1, 8'h01);
    check("p0_src_wen", {28'h0, wen_port}, 32'h0);
    byte_in(1, 8'h10);
    check("p0_dst_wen",   {28'h0, wen_port}, 32'h1);
    check("p0_dst_waddr", {16'h0, waddr_in_port}, 32'h0000);
    check("p0_dst_wdata", wdata_port, 32'h0000_0010);
    byte_in(1, 8'h02);
    check("p0_size_waddr", {16'h0, waddr_in_port}, 32'h0001);
    byte_in(1, 8'hAA);
    check("p0_d0_waddr", {16'h0, waddr_in_port}, 32'h0002);
    check("p0_d0_wdata", wdata_port, 32'h0000_00AA);
    byte_in(1, 8'hBB);
    check("p0_d1_waddr", {16'h0, waddr_in_port}, 32'h0003);
    byte_in(1, 8'h02);
    check("p0_crc_wen",   {28'h0, wen_port}, 32'h1);
    check("p0_crc_waddr", {16'h0, waddr_in_port}, 32'h0004);
    check("p0_crc_winc",  {28'h0, winc_port}, 32'h0);
    byte_in(0, 8'h00);
    check("p0_commit_winc",  {28'h0, winc_port}, 32'h1);
    check("p0_commit_wen",   {28'h0, wen_port}, 32'h0);
    check("p0_commit_waddr", {16'h0, waddr_in_port}, 32'h0);
    check("p0_commit_wdata", wdata_port, 32'h0000_0002);
    check("p0_commit_drop",  {24'h0, drop_cnt}, 32'h0);
    byte_in(0, 8'h00);
    check("p0_after_winc", {28'h0, winc_port}, 32'h0);

    // Untrusted SRC=55 to port 3: nothing written, one drop
    byte_in(1, 8'h55);
    byte_in(1, 8'hC0);
    check("ut_dst_wen", {28'h0, wen_port}, 32'h0);
    byte_in(1, 8'h01);
    byte_in(1, 8'h11);
    check("ut_data_wen", {28'h0, wen_port}, 32'h0);
    byte_in(1, 8'h85);
    check("ut_crc_wen", {28'h0, wen_port}, 32'h0);
    byte_in(0, 8'h00);
    check("ut_winc", {28'h0, winc_port}, 32'h0);
    check("ut_drop", {24'h0, drop_cnt}, 32'h1);

    // Back-to-back: port 3 (SRC=02, SIZE=1) then port 1 (SRC=00, SIZE=0)
    byte_in(1, 8'h02);
    byte_in(1, 8'hC0);
    check("bb1_wen",   {28'h0, wen_port}, 32'h8);
    check("bb1_waddr", {16'h0, waddr_in_port}, 32'h0000);
    check("bb1_wdata", {24'h0, wdata_port[31:24]}, 32'hC0);
    byte_in(1, 8'h01);
    check("bb1_size_waddr", {16'h0, waddr_in_port}, 32'h1000);
    byte_in(1, 8'h33);
    byte_in(1, 8'hF0);
    check("bb1_crc_waddr", {16'h0, waddr_in_port}, 32'h3000);
    byte_in(1, 8'h00);
    check("bb1_winc",   {28'h0, winc_port}, 32'h8);
    check("bb1_waddr0", {16'h0, waddr_in_port}, 32'h0000);
    byte_in(1, 8'h40);
    check("bb2_dst_wen",   {28'h0, wen_port}, 32'h2);
    check("bb2_dst_winc",  {28'h0, winc_port}, 32'h0);
    check("bb2_dst_wdata", {24'h0, wdata_port[15:8]}, 32'h40);
    byte_in(1, 8'h00);
    check("bb2_size_waddr", {16'h0, waddr_in_port}, 32'h0010);
    byte_in(1, 8'h40);
    check("bb2_crc_waddr", {16'h0, waddr_in_port}, 32'h0020);
    byte_in(0, 8'h00);
    check("bb2_winc", {28'h0, winc_port}, 32'h2);
    check("bb2_drop", {24'h0, drop_cnt}, 32'h1);

    // Abort after first DATA byte of a SIZE=3 packet, then a normal packet
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h03);
    byte_in(1, 8'h11);
    check("ab_d0_waddr", {16'h0, waddr_in_port}, 32'h0002);
    byte_in(0, 8'h00);
    check("ab_wen",   {28'h0, wen_port}, 32'h0);
    check("ab_winc",  {28'h0, winc_port}, 32'h0);
    check("ab_waddr", {16'h0, waddr_in_port}, 32'h0);
    check("ab_drop",  {24'h0, drop_cnt}, 32'h2);
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    check("ab_next_dst_waddr", {16'h0, waddr_in_port}, 32'h0000);
    byte_in(1, 8'h01);
    byte_in(1, 8'h77);
    byte_in(1, 8'h67);
    byte_in(0, 8'h00);
    check("ab_next_winc", {28'h0, winc_port}, 32'h1);
    check("ab_next_drop", {24'h0, drop_cnt}, 32'h2);

    // Port 2 goes full while its packet is in flight
    byte_in(1, 8'h00);
    wfull_port = 4'b0100;
    byte_in(1, 8'h80);
    check("full_dst_wen", {28'h0, wen_port}, 32'h0);
    check("full_stop",    {31'h0, stop_packet_send}, 32'h1);
    byte_in(1, 8'h00);
    check("full_size_wen", {28'h0, wen_port}, 32'h0);
    byte_in(1, 8'h80);
    byte_in(1, 8'h01);
    check("full_winc", {28'h0, winc_port}, 32'h0);
    check("full_drop", {24'h0, drop_cnt}, 32'h3);
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    check("full_idle_wen", {28'h0, wen_port}, 32'h0);
    wfull_port = 4'b0000;
    byte_in(0, 8'h00);
    check("full_release_stop", {31'h0, stop_packet_send}, 32'h0);

    // SIZE=13 is the largest kept packet: offsets run to 15
    x = 8'h01 ^ 8'h10 ^ 8'h0D;
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h0D);
    for (int i = 0; i < 13; i++) begin
      byte_in(1, 8'(i + 1));
      x = x ^ 8'(i + 1);
    end
    byte_in(1, x);
    check("max_crc_waddr", {16'h0, waddr_in_port}, 32'h000F);
    byte_in(0, 8'h00);
    check("max_winc", {28'h0, winc_port}, 32'h1);
    check("max_drop", {24'h0, drop_cnt}, 32'h3);

    // SIZE=14 exceeds capacity: dropped at the SIZE byte
    x = 8'h01 ^ 8'h10 ^ 8'h0E;
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h0E);
    check("over_size_wen", {28'h0, wen_port}, 32'h0);
    for (int i = 0; i < 14; i++) begin
      byte_in(1, 8'(i));
      x = x ^ 8'(i);
    end
    byte_in(1, x);
    byte_in(0, 8'h00);
    check("over_winc", {28'h0, winc_port}, 32'h0);
    check("over_drop", {24'h0, drop_cnt}, 32'h4);

    // Drop counter saturates at all-ones
    for (int i = 0; i < 252; i++) begin
      byte_in(1, 8'h55);
      byte_in(1, 8'h00);
      byte_in(1, 8'h00);
      byte_in(1, 8'h55);
      byte_in(0, 8'h00);
    end
    check("sat_drop", {24'h0, drop_cnt}, 32'hFF);

    // Asynchronous reset in the middle of DATA
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h03);
    byte_in(1, 8'hAA);
    #2 rst = 1'b1;
    #1;
    check("rstmid_wen",   {28'h0, wen_port}, 32'h0);
    check("rstmid_waddr", {16'h0, waddr_in_port}, 32'h0);
    check("rstmid_wdata", wdata_port, 32'h0);
    check("rstmid_drop",  {24'h0, drop_cnt}, 32'h0);
    packet_valid_i = 1'b0;
    @(posedge clk1);
    #1 rst = 1'b0;
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h02);
    byte_in(1, 8'hAA);
    byte_in(1, 8'hBB);
    byte_in(1, 8'h02);
    byte_in(0, 8'h00);
    check("rstmid_next_winc", {28'h0, winc_port}, 32'h1);
    check("rstmid_next_drop", {24'h0, drop_cnt}, 32'h0);

    // Wrong CRC byte (correct value is BA)
    byte_in(1, 8'h01);
    byte_in(1, 8'h10);
    byte_in(1, 8'h01);
    byte_in(1, 8'hAA);
    byte_in(1, 8'h00);
    byte_in(0, 8'h00);
`ifdef CRC_CHECK_EN
    check("badcrc_err",  {31'h0, crc_err}, 32'h1);
    check("badcrc_winc", {28'h0, winc_port}, 32'h0);
    check("badcrc_drop", {24'h0, drop_cnt}, 32'h1);
    byte_in(0, 8'h00);
    check("badcrc_err_end", {31'h0, crc_err}, 32'h0);
`else
    check("nocrc_err",  {31'h0, crc_err}, 32'h0);
    check("nocrc_winc", {28'h0, winc_port}, 32'h1);
    check("nocrc_drop", {24'h0, drop_cnt}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
